// File: rtl/miriscv_fetch_buffer_stage.sv
// miriscv_fetch_buffer_stage: multi-outstanding instruction fetch with prefetch FIFO and stallable output register
// Optional MIRISCV_FETCH_PERF_EN adds f_starve_cnt_o (saturating starvation-cycle counter).
module miriscv_fetch_buffer_stage #(
  parameter int XLEN            = 32,
  parameter int ILEN            = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] boot_addr_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic [XLEN-1:0] cu_pc_bra_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_boot_addr_load_en_i,
  input  logic            cu_stall_f_i,
  output logic [ILEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  output logic [XLEN-1:0] f_next_pc_o,
`ifdef MIRISCV_FETCH_PERF_EN
  output logic [31:0]     f_starve_cnt_o,
`endif
  output logic            f_valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]   C_MAXO  = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0]   Q_LAST  = QW'(MAX_OUTSTANDING - 1);
  localparam logic [ILEN-1:0] NOP     = ILEN'(32'h00000013);

  logic [XLEN-1:0] r_req_pc;
  logic [ILEN-1:0] r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count, r_outstanding, r_drop;
  logic [XLEN-1:0] r_pcq [MAX_OUTSTANDING];
  logic [QW-1:0]   r_pcq_wr, r_pcq_rd;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc, r_next_pc;
  logic            r_valid;

  logic            w_flush, w_req, w_issue, w_rsp, w_push, w_pop;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_sum;
  logic [CW-1:0]   w_out_next;

  always_comb begin
    w_flush    = cu_boot_addr_load_en_i | cu_kill_f_i;
    w_target   = cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;
    w_sum      = {1'b0, r_outstanding} + {1'b0, r_count};
    w_req      = !rst_i && !w_flush && (r_outstanding < C_MAXO) && (w_sum < {1'b0, C_DEPTH});
    w_issue    = w_req && instr_gnt_i;
    // responses with nothing outstanding (e.g. stragglers from before reset) are illegal and ignored
    w_rsp      = instr_rvalid_i && (r_outstanding != '0);
    w_push     = w_rsp && (r_drop == '0) && !w_flush;
    w_pop      = !cu_stall_f_i && (r_count != '0) && !w_flush;
    w_out_next = r_outstanding + CW'(w_issue) - CW'(w_rsp);
  end

  assign instr_req_o    = w_req;
  assign instr_addr_o   = r_req_pc;
  assign f_instr_o      = r_instr;
  assign f_current_pc_o = r_pc;
  assign f_next_pc_o    = r_next_pc;
  assign f_valid_o      = r_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_pc      <= boot_addr_i;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
      r_instr       <= NOP;
      r_pc          <= '0;
      r_next_pc     <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      // the PC queue tracks every granted request so it stays aligned with in-order responses across flushes
      if (w_issue) begin
        r_pcq[r_pcq_wr] <= r_req_pc;
        r_pcq_wr        <= (r_pcq_wr == Q_LAST) ? '0 : r_pcq_wr + QW'(1);
      end
      if (w_rsp)
        r_pcq_rd <= (r_pcq_rd == Q_LAST) ? '0 : r_pcq_rd + QW'(1);
      if (w_flush) begin
        r_req_pc <= w_target;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= w_out_next;
        r_instr  <= NOP;
        r_valid  <= 1'b0;
      end else begin
        if (w_issue)
          r_req_pc <= r_req_pc + XLEN'(4);
        if (w_rsp && r_drop != '0)
          r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_fifo_instr[r_wr_ptr] <= instr_rdata_i[ILEN-1:0];
          r_fifo_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
          r_wr_ptr               <= r_wr_ptr + AW'(1);
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (!cu_stall_f_i) begin
          r_instr <= w_pop ? r_fifo_instr[r_rd_ptr] : NOP;
          r_valid <= w_pop;
          if (w_pop) begin
            r_pc      <= r_fifo_pc[r_rd_ptr];
            r_next_pc <= r_fifo_pc[r_rd_ptr] + XLEN'(4);
          end
        end
      end
    end
  end

`ifdef MIRISCV_FETCH_PERF_EN
  logic [31:0] r_starve;
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_starve <= '0;
    else if (!cu_stall_f_i && r_count == '0 && !w_flush && r_starve != '1)
      r_starve <= r_starve + 32'd1;
  end
  assign f_starve_cnt_o = r_starve;
`endif
endmodule

// File: tb/tb_miriscv_fetch_buffer_stage.sv
// tb_miriscv_fetch_buffer_stage: in-order memory model with scoreboard of expected {pc, instr} for the fetch stage
module tb_miriscv_fetch_buffer_stage;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] BOOT = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] boot_addr_i = BOOT;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic [31:0] cu_pc_bra_i = '0;
  logic        cu_kill_f_i = 1'b0;
  logic        cu_boot_addr_load_en_i = 1'b0;
  logic        cu_stall_f_i = 1'b0;
  logic [31:0] f_instr_o, f_current_pc_o, f_next_pc_o;
  logic        f_valid_o;
`ifdef MIRISCV_FETCH_PERF_EN
  logic [31:0] f_starve_cnt_o;
`endif

  miriscv_fetch_buffer_stage dut (
    .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .cu_pc_bra_i(cu_pc_bra_i), .cu_kill_f_i(cu_kill_f_i),
    .cu_boot_addr_load_en_i(cu_boot_addr_load_en_i), .cu_stall_f_i(cu_stall_f_i),
    .f_instr_o(f_instr_o), .f_current_pc_o(f_current_pc_o), .f_next_pc_o(f_next_pc_o),
`ifdef MIRISCV_FETCH_PERF_EN
    .f_starve_cnt_o(f_starve_cnt_o),
`endif
    .f_valid_o(f_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int gen; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  pend_t pend[$];
  exp_t  sb[$];

  int vectors = 0, errors = 0, cyc = 0, gen = 0, lat = 1;
  bit gnt_en = 1'b1, rsp_en = 1'b1, last_stall = 1'b0;
  logic [31:0] exp_pc = '0;

  // One clock cycle: drive memory at negedge, sample, then update model and check outputs after posedge
  task automatic step();
    bit s_req, s_gnt, s_rsp, s_rst, s_flush, s_stall;
    logic [31:0] s_addr, tgt;
    int c;
    pend_t p;
    exp_t e;
    @(negedge clk);
    c = cyc;
    instr_gnt_i    = gnt_en;
    instr_rvalid_i = rsp_en && pend.size() > 0 && pend[0].due <= c;
    instr_rdata_i  = instr_rvalid_i ? ~pend[0].addr : 32'hDEADBEEF;
    #1;
    s_req   = instr_req_o;
    s_addr  = instr_addr_o;
    s_gnt   = instr_gnt_i;
    s_rsp   = instr_rvalid_i;
    s_rst   = rst_i;
    s_flush = cu_kill_f_i | cu_boot_addr_load_en_i;
    tgt     = cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;
    s_stall = cu_stall_f_i;
    @(posedge clk);
    #1;
    cyc++;
    last_stall = s_stall;
    if (s_rst || s_flush) begin
      gen++;
      sb.delete();
      exp_pc = s_rst ? boot_addr_i : tgt;
      vectors++;
      if (s_req !== 1'b0) begin
        errors++;
        $display("FAIL req_during_flush: instr_req_o=%b expected 0", s_req);
      end
    end
    if (s_rsp) begin
      p = pend.pop_front();
      if (p.gen == gen) sb.push_back('{p.addr, ~p.addr});
    end
    if (s_req && s_gnt && !s_rst) begin
      vectors++;
      if (s_addr !== exp_pc) begin
        errors++;
        $display("FAIL grant_addr: got %h expected %h", s_addr, exp_pc);
      end
      pend.push_back('{s_addr, gen, c + lat});
      exp_pc += 32'd4;
    end
    if (s_flush && !s_rst) begin
      vectors++;
      if (f_valid_o !== 1'b0 || f_instr_o !== NOP) begin
        errors++;
        $display("FAIL flush_out: valid=%b instr=%h expected valid=0 instr=%h", f_valid_o, f_instr_o, NOP);
      end
    end else if (!s_rst && !s_stall && f_valid_o === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: pc=%h instr=%h expected no valid output", f_current_pc_o, f_instr_o);
      end else begin
        e = sb.pop_front();
        if (f_instr_o !== e.instr || f_current_pc_o !== e.pc || f_next_pc_o !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL output: got pc=%h next=%h instr=%h expected pc=%h next=%h instr=%h",
                   f_current_pc_o, f_next_pc_o, f_instr_o, e.pc, e.pc + 32'd4, e.instr);
        end
      end
    end
  endtask

  task automatic run_until_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (f_valid_o === 1'b1) && !last_stall;
    end
  endtask

  task automatic test_reset();
    bit found;
    rst_i = 1'b1;
    step();
    step();
    vectors++;
    if (f_instr_o !== NOP || f_current_pc_o !== 32'h0 || f_next_pc_o !== 32'h0 || f_valid_o !== 1'b0 || instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: instr=%h pc=%h next=%h valid=%b req=%b expected %h 0 0 0 0",
               f_instr_o, f_current_pc_o, f_next_pc_o, f_valid_o, instr_req_o, NOP);
    end
`ifdef MIRISCV_FETCH_PERF_EN
    vectors++;
    if (f_starve_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL starve_reset: got %0d expected 0", f_starve_cnt_o);
    end
`endif
    rst_i = 1'b0;
    step();
`ifdef MIRISCV_FETCH_PERF_EN
    vectors++;
    if (f_starve_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL starve_count: got %0d expected 1", f_starve_cnt_o);
    end
`endif
    run_until_valid(found);
    vectors++;
    if (!found || f_current_pc_o !== BOOT || f_next_pc_o !== BOOT + 32'd4) begin
      errors++;
      $display("FAIL first_fetch: found=%b pc=%h next=%h expected pc=%h next=%h", found, f_current_pc_o, f_next_pc_o, BOOT, BOOT + 32'd4);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (f_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL throughput: valid=%b expected 1 at cycle %0d", f_valid_o, i);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ins0, pc0;
    logic v0;
    ins0 = f_instr_o;
    pc0 = f_current_pc_o;
    v0 = f_valid_o;
    cu_stall_f_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (f_instr_o !== ins0 || f_current_pc_o !== pc0 || f_valid_o !== v0) begin
        errors++;
        $display("FAIL stall_hold: got instr=%h pc=%h valid=%b expected %h %h %b", f_instr_o, f_current_pc_o, f_valid_o, ins0, pc0, v0);
      end
    end
    vectors++;
    if (instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_full_req: instr_req_o=%b expected 0", instr_req_o);
    end
    cu_stall_f_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (f_valid_o !== 1'b1 || f_current_pc_o !== pc0 + 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL stall_drain: valid=%b pc=%h expected valid=1 pc=%h", f_valid_o, f_current_pc_o, pc0 + 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_kill();
    bit found;
    lat = 3;
    for (int i = 0; i < 10 && pend.size() < 2; i++) step();
    vectors++;
    if (pend.size() != 2) begin
      errors++;
      $display("FAIL kill_setup: outstanding=%0d expected 2", pend.size());
    end
    cu_pc_bra_i = 32'h00001000;
    cu_kill_f_i = 1'b1;
    step();
    cu_kill_f_i = 1'b0;
    lat = 1;
    run_until_valid(found);
    vectors++;
    if (!found || f_current_pc_o !== 32'h00001000) begin
      errors++;
      $display("FAIL kill_redirect: found=%b pc=%h expected pc=00001000", found, f_current_pc_o);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a0;
    a0 = instr_addr_o;
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== a0 || pend.size() > 2) begin
        errors++;
        $display("FAIL gnt_hold: req=%b addr=%h outstanding=%0d expected req=1 addr=%h outstanding<=2",
                 instr_req_o, instr_addr_o, pend.size(), a0);
      end
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_wrap();
    bit found;
    cu_pc_bra_i = 32'hFFFFFFFC;
    cu_kill_f_i = 1'b1;
    step();
    cu_kill_f_i = 1'b0;
    run_until_valid(found);
    vectors++;
    if (!found || f_current_pc_o !== 32'hFFFFFFFC || f_next_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_last: found=%b pc=%h next=%h expected FFFFFFFC 00000000", found, f_current_pc_o, f_next_pc_o);
    end
    step();
    vectors++;
    if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_first: valid=%b pc=%h expected valid=1 pc=00000000", f_valid_o, f_current_pc_o);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_boot_load();
    bit found;
    cu_pc_bra_i = 32'h00002000;
    cu_kill_f_i = 1'b1;
    cu_boot_addr_load_en_i = 1'b1;
    step();
    cu_kill_f_i = 1'b0;
    cu_boot_addr_load_en_i = 1'b0;
    run_until_valid(found);
    vectors++;
    if (!found || f_current_pc_o !== BOOT) begin
      errors++;
      $display("FAIL boot_priority: found=%b pc=%h expected pc=%h", found, f_current_pc_o, BOOT);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_mid();
    bit found;
    lat = 2;
    cu_stall_f_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    gnt_en = 1'b0;
    for (int i = 0; i < 8 && pend.size() > 1; i++) step();
    rsp_en = 1'b0;
    rst_i = 1'b1;
    step();
    vectors++;
    if (f_instr_o !== NOP || f_current_pc_o !== 32'h0 || f_next_pc_o !== 32'h0 || f_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values: instr=%h pc=%h next=%h valid=%b expected %h 0 0 0",
               f_instr_o, f_current_pc_o, f_next_pc_o, f_valid_o, NOP);
    end
`ifdef MIRISCV_FETCH_PERF_EN
    vectors++;
    if (f_starve_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_starve: got %0d expected 0", f_starve_cnt_o);
    end
`endif
    rst_i = 1'b0;
    cu_stall_f_i = 1'b0;
    rsp_en = 1'b1;
    step();
    vectors++;
    if (f_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== BOOT) begin
      errors++;
      $display("FAIL late_rvalid: valid=%b req=%b addr=%h expected 0 1 %h", f_valid_o, instr_req_o, instr_addr_o, BOOT);
    end
`ifdef MIRISCV_FETCH_PERF_EN
    vectors++;
    if (f_starve_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL midreset_starve_inc: got %0d expected 1", f_starve_cnt_o);
    end
`endif
    pend.delete();
    gnt_en = 1'b1;
    lat = 1;
    run_until_valid(found);
    vectors++;
    if (!found || f_current_pc_o !== BOOT) begin
      errors++;
      $display("FAIL restart: found=%b pc=%h expected pc=%h", found, f_current_pc_o, BOOT);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_kill();
    test_gnt_hold();
    test_wrap();
    test_boot_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/miriscv_fetch_buffer_stage.md
Name: miriscv_fetch_buffer_stage

Overview:
- Next-generation fetch stage for the miriscv core.
- Keeps up to MAX_OUTSTANDING instruction-memory requests in flight and buffers returned words in a DEPTH-entry prefetch FIFO.
- Presents one instruction per cycle to Decode through a stallable pipeline register.
- Sits between the instruction memory and the decode stage. Driven by the control unit's kill, stall and boot-load controls.

Parameters:
- XLEN, 32, address/data width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, max requests granted but not yet answered (1..DEPTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- boot_addr_i  in  XLEN  reset/boot PC.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  XLEN  request address (word-aligned).
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  response valid (in-order).
- instr_rdata_i  in  XLEN  response data.
- cu_pc_bra_i  in  XLEN  redirect target.
- cu_kill_f_i  in  1  flush and redirect to cu_pc_bra_i.
- cu_boot_addr_load_en_i  in  1  flush and redirect to boot_addr_i.
- cu_stall_f_i  in  1  hold the output register.
- f_instr_o  out  ILEN  instruction to Decode.
- f_current_pc_o  out  XLEN  PC of f_instr_o.
- f_next_pc_o  out  XLEN  f_current_pc_o+4.
- f_valid_o  out  1  f_instr_o is real.

Behaviour:
- Reset (rst_i=1 at posedge):
  - req_pc=boot_addr_i; FIFO empty; outstanding=0; drop=0.
  - f_instr_o=32'h00000013 (NOP), f_current_pc_o=0, f_next_pc_o=0, f_valid_o=0, instr_req_o=0.
  - rst_i asserted mid-transaction abandons all state. Responses arriving after reset are ignored while drop=0, because outstanding=0 makes them illegal.
- Request issue:
  - instr_req_o=1 when not reset, no kill/boot-load this cycle, outstanding<MAX_OUTSTANDING and (outstanding+fifo_count)<DEPTH.
  - instr_addr_o=req_pc.
  - Request and address stay stable until gnt.
  - On req&gnt: req_pc+=4 (XLEN wrap-around allowed), outstanding+=1.
- Response:
  - On rvalid, outstanding-=1.
  - If drop>0: drop-=1 and the word is discarded.
  - Otherwise push {rdata, pc}. The PC comes from a parallel response-PC queue of depth MAX_OUTSTANDING.
  - The FIFO never overflows, by construction of the issue rule.
- Same-cycle gnt and rvalid: outstanding unchanged.
- Pop: when cu_stall_f_i=0 and FIFO non-empty, the output register loads the head; f_valid_o=1; f_next_pc_o=pc+4.
- Stall/empty output:
  - When cu_stall_f_i=0 and FIFO empty: f_instr_o=NOP, f_valid_o=0; f_current_pc_o and f_next_pc_o hold.
  - When cu_stall_f_i=1: all outputs hold; FIFO keeps filling.
- Push and pop in the same cycle are allowed, including when the FIFO is full.
- Kill / boot-load (priority: rst_i > cu_boot_addr_load_en_i > cu_kill_f_i):
  - Next cycle: req_pc=target, FIFO flushed, drop=outstanding, with any same-cycle rvalid accounted for.
  - The output register loads NOP with f_valid_o=0, even if cu_stall_f_i=1.
  - No request is issued during the flush cycle.
  - A kill while drop>0 adds the new outstanding count to drop.
- Latency:
  - Redirect to first request: 1 cycle.
  - rvalid to f_valid_o, FIFO empty and no stall: 2 cycles (FIFO write, then output register).

Optional Feature:
- MIRISCV_FETCH_PERF_EN defined:
  - Adds output f_starve_cnt_o (32 bit).
  - Counts cycles where cu_stall_f_i=0, FIFO empty and no flush.
  - Saturates at 32'hFFFFFFFF; reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with boot_addr_i=32'h80000000, memory gnt=1 and rvalid 1 cycle later → instr_addr_o sequence 8000_0000, 8000_0004, …; first f_valid_o=1 with f_current_pc_o=8000_0000, f_next_pc_o=8000_0004; thereafter one instruction per cycle.
- cu_stall_f_i=1 for 10 cycles with memory always granting → FIFO fills to DEPTH=4; instr_req_o drops to 0; outputs hold; after release, 4 buffered words emerge on consecutive cycles in PC order.
- Kill to 32'h00001000 while 2 requests are outstanding → next 2 rvalid words are discarded; first valid output has PC 0000_1000; no stale PC ever appears with f_valid_o=1.
- gnt withheld for 5 cycles → instr_req_o and instr_addr_o stay stable; outstanding never exceeds MAX_OUTSTANDING=2.
- req_pc=32'hFFFFFFFC → next request address is 32'h00000000; f_next_pc_o=0 for that instruction.
- rst_i asserted with FIFO half-full and 1 outstanding → next cycle all outputs are at reset values; a late rvalid is ignored; fetch restarts at boot_addr_i. With MIRISCV_FETCH_PERF_EN, f_starve_cnt_o=0 after reset and increments on empty cycles.
